// File: rtl/serial_div_pkg.sv
// Shared widths, handshake levels, state encoding and result payload for serial_div.
package serial_div_pkg;

    localparam int unsigned reg_bus        = 32;
    localparam int unsigned double_reg_bus = 64;
    localparam int unsigned cnt_w          = 5;

    localparam logic [reg_bus-1:0]        zero_word        = '0;
    localparam logic [double_reg_bus-1:0] zero_double_word = '0;

    localparam logic div_res_ready     = 1'b1;
    localparam logic div_res_not_ready = 1'b0;
    localparam logic div_start         = 1'b1;
    localparam logic div_stop          = 1'b0;

    // Counter value at which the final (32nd) iteration is being performed.
    localparam logic [cnt_w-1:0] last_iter = cnt_w'(reg_bus - 1);

    typedef enum logic [1:0] {
        div_free    = 2'b00,
        div_by_zero = 2'b01,
        div_on      = 2'b10,
        div_end     = 2'b11
    } div_state_e;

    // HI/LO write payload: remainder in the upper word, quotient in the lower.
    typedef struct packed {
        logic [reg_bus-1:0] rem;
        logic [reg_bus-1:0] quot;
    } div_result_t;

    // Two's-complement negation of a register word.
    function automatic logic [reg_bus-1:0] neg_word(input logic [reg_bus-1:0] x);
        return ~x + reg_bus'(1);
    endfunction

    // Operand magnitude: negative operands are negated only in signed mode.
    function automatic logic [reg_bus-1:0] magnitude(input logic               sgn_mode,
                                                     input logic [reg_bus-1:0] x);
        return (sgn_mode && x[reg_bus-1]) ? neg_word(x) : x;
    endfunction

endpackage

// File: rtl/serial_div_if.sv
// EX-stage <-> divider request/response bundle.
interface serial_div_if;
    import serial_div_pkg::*;

    logic               signed_div_i;
    logic [reg_bus-1:0] opdata1_i;
    logic [reg_bus-1:0] opdata2_i;
    logic               start_i;
    logic               annul_i;
    div_result_t        result_o;
    logic               ready_o;

    // EX side: issues the request and consumes the result.
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    // Divider side.
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/serial_div.sv
// serial_div: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Optional feature macro: DIV_ZERO_CHECK_EN -- when defined, a zero divisor
// short-circuits through the DivByZero state and returns 0 after 2 cycles;
// when undefined, a zero divisor runs all 32 iterations.
module serial_div
    import serial_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    serial_div_if.slave bus
);

    div_state_e         state, state_n;

    logic               signed_q,  signed_n;
    logic               dvd_neg_q, dvd_neg_n;
    logic               dvs_neg_q, dvs_neg_n;
    logic [reg_bus-1:0] divisor_q, divisor_n;
    // Partial remainder. The 33rd bit is always zero between iterations
    // (R < divisor), so only the low 32 bits are stored; the subtractor
    // below still works on the full 33-bit shifted value.
    logic [reg_bus-1:0] rem_q,     rem_n;
    logic [reg_bus-1:0] quot_q,    quot_n;
    logic [cnt_w-1:0]   cnt_q,     cnt_n;
    div_result_t        result_q,  result_n;
    logic               ready_q,   ready_n;

    logic [reg_bus:0]   trial;
    logic [reg_bus-1:0] rem_step;
    logic [reg_bus-1:0] quot_step;
    logic               accept;

    // One restoring step: trial subtract of the divisor from the shifted remainder.
    always_comb begin
        trial     = {rem_q, quot_q[reg_bus-1]} - {1'b0, divisor_q};
        rem_step  = trial[reg_bus] ? {rem_q[reg_bus-2:0], quot_q[reg_bus-1]}
                                   : trial[reg_bus-1:0];
        quot_step = {quot_q[reg_bus-2:0], ~trial[reg_bus]};
        accept    = (bus.start_i == div_start) && !bus.annul_i;
    end

    // Next-state and next-register values for the divider FSM.
    always_comb begin
        state_n   = state;
        signed_n  = signed_q;
        dvd_neg_n = dvd_neg_q;
        dvs_neg_n = dvs_neg_q;
        divisor_n = divisor_q;
        rem_n     = rem_q;
        quot_n    = quot_q;
        cnt_n     = cnt_q;
        result_n  = result_q;
        ready_n   = ready_q;

        unique case (state)
            div_free: begin
                if (accept) begin
                    signed_n  = bus.signed_div_i;
                    dvd_neg_n = bus.opdata1_i[reg_bus-1];
                    dvs_neg_n = bus.opdata2_i[reg_bus-1];
                    divisor_n = magnitude(bus.signed_div_i, bus.opdata2_i);
                    rem_n     = zero_word;
                    quot_n    = magnitude(bus.signed_div_i, bus.opdata1_i);
                    cnt_n     = '0;
`ifdef DIV_ZERO_CHECK_EN
                    if (bus.opdata2_i == zero_word) begin
                        state_n = div_by_zero;
                    end else begin
                        state_n = div_on;
                    end
`else
                    state_n   = div_on;
`endif
                end
            end

            div_by_zero: begin
                result_n = zero_double_word;
                ready_n  = div_res_ready;
                state_n  = div_end;
            end

            div_on: begin
                if (bus.annul_i || (bus.start_i == div_stop)) begin
                    // Abort: drop the partial state; no result is produced.
                    rem_n   = zero_word;
                    quot_n  = zero_word;
                    cnt_n   = '0;
                    state_n = div_free;
                end else begin
                    rem_n  = rem_step;
                    quot_n = quot_step;
                    cnt_n  = cnt_q + cnt_w'(1);
                    if (cnt_q == last_iter) begin
                        // Sign fix-up: quotient follows sign XOR, remainder follows dividend.
                        result_n.quot = (signed_q && (dvd_neg_q != dvs_neg_q))
                                        ? neg_word(quot_step) : quot_step;
                        result_n.rem  = (signed_q && dvd_neg_q)
                                        ? neg_word(rem_step) : rem_step;
                        ready_n       = div_res_ready;
                        state_n       = div_end;
                    end
                end
            end

            div_end: begin
                // annul is deliberately ignored once the result is ready.
                if (bus.start_i == div_stop) begin
                    result_n = zero_double_word;
                    ready_n  = div_res_not_ready;
                    state_n  = div_free;
                end
            end

            default: begin
                state_n = div_free;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= div_free;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and registered output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            signed_q  <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            divisor_q <= zero_word;
            rem_q     <= zero_word;
            quot_q    <= zero_word;
            cnt_q     <= '0;
            result_q  <= zero_double_word;
            ready_q   <= div_res_not_ready;
        end else begin
            signed_q  <= signed_n;
            dvd_neg_q <= dvd_neg_n;
            dvs_neg_q <= dvs_neg_n;
            divisor_q <= divisor_n;
            rem_q     <= rem_n;
            quot_q    <= quot_n;
            cnt_q     <= cnt_n;
            result_q  <= result_n;
            ready_q   <= ready_n;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_serial_div.sv
// Self-checking bench for serial_div: directed table, corner sequences, random vs. reference model.
module tb_serial_div;
    import serial_div_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_div_if dif();

    serial_div dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_CHECK_EN
            return 64'd0;
`else
            // Restoring divide by zero: magnitude quotient all-ones, remainder = |a|, then sign fix-up.
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
            return {r, q};
`endif
        end
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_CHECK_EN
        return (b == 32'd0) ? 2 : 33;
`else
        return (b == 32'd0) ? 33 : 33;
`endif
    endfunction

    // Full transaction: request, wait for ready, check, annul in DivEnd, release.
    task automatic run_div(input string name, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                           input bit scramble);
        int lat;
        dif.signed_div_i = sgn;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.annul_i      = 1'b0;
        dif.start_i      = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (scramble) begin
                dif.signed_div_i = 1'($urandom_range(0, 1));
                dif.opdata1_i    = $urandom;
                dif.opdata2_i    = $urandom;
            end
        end while (!dif.ready_o && lat < 100);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, dif.result_o, exp);
        dif.annul_i = 1'b1;
        @(posedge clk);
        #1;
        dif.annul_i = 1'b0;
        check({name, " hold ready"}, 64'(dif.ready_o), 64'd1);
        check({name, " hold result"}, dif.result_o, exp);
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, " release ready"}, 64'(dif.ready_o), 64'd0);
        check({name, " release result"}, dif.result_o, 64'd0);
    endtask

    // Start 100/7, then abort after 'iters' cycles in DivOn via annul or start drop.
    task automatic abort_run(input string name, input bit use_annul, input int iters);
        bit seen;
        seen = 1'b0;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd100;
        dif.opdata2_i    = 32'd7;
        dif.annul_i      = 1'b0;
        dif.start_i      = 1'b1;
        repeat (iters + 1) begin
            @(posedge clk);
            #1;
            seen |= dif.ready_o;
        end
        if (use_annul) dif.annul_i = 1'b1;
        else           dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        seen |= dif.ready_o;
        if (!use_annul) begin
            // Keep start low one more edge in DivFree before the next request.
            @(posedge clk);
            #1;
            seen |= dif.ready_o;
        end
        check({name, " no ready"}, 64'(seen), 64'd0);
        check({name, " result idle"}, dif.result_o, 64'd0);
        // Fresh request right away: must take the full latency and give 9/3.
        run_div({name, " then 9/3"}, 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0);
    endtask

    initial begin
        int          lat;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;

        tbl[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        64'hFFFFFFFF_FFFFFFFD, 33};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33};
        tbl[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 64'h00000000_80000000, 33};
`ifdef DIV_ZERO_CHECK_EN
        tbl[4] = '{1'b0, 32'h0000_1234,  32'd0,        64'h00000000_00000000, 2};
`else
        tbl[4] = '{1'b0, 32'h0000_1234,  32'd0,        64'h00001234_FFFFFFFF, 33};
`endif
        tbl[5] = '{1'b0, 32'd9,          32'd3,        64'h00000000_00000003, 33};
        tbl[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        64'h00000000_FFFFFFFF, 33};
        tbl[7] = '{1'b0, 32'd5,          32'd10,       64'h00000005_00000000, 33};
        tbl[8] = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 64'hFFFFFFFE_00000002, 33};
        tbl[9] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 64'h80000000_00000000, 33};

        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = '0;
        dif.opdata2_i    = '0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(dif.ready_o), 64'd0);
        check("reset result", dif.result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_div($sformatf("tbl%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b,
                    tbl[i].exp, tbl[i].lat, 1'b0);
        end

        // Aborts in DivOn.
        abort_run("annul", 1'b1, 9);
        abort_run("stopdrop", 1'b0, 15);

        // Operands changing during DivOn must not matter.
        run_div("scramble", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b1);

        // Reset at iteration 20, then a fresh request straight after release.
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd100;
        dif.opdata2_i    = 32'd7;
        dif.start_i      = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst mid ready", 64'(dif.ready_o), 64'd0);
        check("rst mid result", dif.result_o, 64'd0);
        rst = 1'b0;
        run_div("after rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0);

        // Reset while a result is being held.
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd100;
        dif.opdata2_i    = 32'd7;
        dif.start_i      = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!dif.ready_o && lat < 100);
        check("pre rst end result", dif.result_o, 64'h00000002_0000000E);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst end ready", 64'(dif.ready_o), 64'd0);
        check("rst end result", dif.result_o, 64'd0);
        rst = 1'b0;
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;

        // start and annul together in DivFree: annul wins, start accepted one edge later.
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd100;
        dif.opdata2_i    = 32'd7;
        dif.start_i      = 1'b1;
        dif.annul_i      = 1'b1;
        @(posedge clk);
        #1;
        dif.annul_i = 1'b0;
        lat = 1;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!dif.ready_o && lat < 100);
        check("annul+start latency", 64'(lat), 64'd34);
        check("annul+start result", dif.result_o, 64'h00000002_0000000E);
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        check("annul+start release", 64'(dif.ready_o), 64'd0);

        // Random operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = ~32'($urandom_range(0, 19));
                3:       b = 32'd0;
                default: b = 32'($urandom_range(1, 1000));
            endcase
            if (i % 7 == 0) a = 32'h8000_0000;
            run_div($sformatf("rnd%0d", i), sgn, a, b, ref_div(sgn, a, b), ref_lat(b), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
